iter_div_ctrl: RTL

Sequential restoring-division controller for an unsigned divider. It time-multiplexes one shift/compare/subtract stage over DIVIDEND_BITS cycles instead of instantiating DIVIDEND_BITS unrolled stages. It sits between a requesting unit and the consumer of the quotient, with valid/ready handshakes on both sides. It produces one quotient bit per cycle, MSB first.

---
 rtl/iter_div_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/iter_div_ctrl.sv
// Sequential restoring divider: one shift/compare/subtract step per clock, MSB-first quotient,
// with valid/ready handshakes on the request and result sides.
module iter_div_ctrl #(
  parameter int DIVIDEND_BITS = 20,
  parameter int DIVISOR_BITS  = 10,
  parameter int CNT_BITS      = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DIVIDEND_BITS-1:0] dividend,
  input  logic [DIVISOR_BITS-1:0]  divisor,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DIVIDEND_BITS-1:0] quotient,
  output logic [DIVISOR_BITS-1:0]  remainder,
  output logic                     div_by_zero,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_BITS-1:0] LAST_ITER = CNT_BITS'(DIVIDEND_BITS - 1);

  state_t                   state;
  logic [DIVIDEND_BITS-1:0] q_reg;
  logic [DIVISOR_BITS-1:0]  r_reg;
  logic [DIVISOR_BITS-1:0]  d_reg;
  logic [CNT_BITS-1:0]      counter;

  logic [DIVISOR_BITS:0]    trial;
  logic                     fits;
  logic [DIVISOR_BITS-1:0]  r_next;
  logic [DIVIDEND_BITS-1:0] q_next;

  // The partial remainder is always below the divisor after a restoring step, so its
  // extra top bit is zero and only DIVISOR_BITS of it need to be stored.
  always_comb begin
    trial  = {r_reg, q_reg[DIVIDEND_BITS-1]};
    fits   = trial >= {1'b0, d_reg};
    r_next = fits ? DIVISOR_BITS'(trial - {1'b0, d_reg}) : trial[DIVISOR_BITS-1:0];
    q_next = {q_reg[DIVIDEND_BITS-2:0], fits};
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      q_reg       <= '0;
      r_reg       <= '0;
      d_reg       <= '0;
      counter     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              state       <= DONE;
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              q_reg   <= dividend;
              r_reg   <= '0;
              d_reg   <= divisor;
              counter <= '0;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          q_reg   <= q_next;
          r_reg   <= r_next;
          counter <= counter + CNT_BITS'(1);
          if (counter == LAST_ITER) begin
            state       <= DONE;
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
